// File: rtl/iq_upconverter_if.sv
// Stream and control bundle for the IQ upconverter: complex baseband in, real IF out,
// NCO frequency/phase control and the sticky saturation flag.
interface iq_upconverter_if #(
    parameter int unsigned WIDTH_DATA = 14,
    parameter int unsigned ACC_WIDTH  = 32
);
    logic [ACC_WIDTH-1:0]         code;
    logic                         code_wr;
    logic                         phase_clr;
    logic                         in_valid;
    logic signed [WIDTH_DATA-1:0] i_in;
    logic signed [WIDTH_DATA-1:0] q_in;
    logic                         out_valid;
    logic signed [WIDTH_DATA-1:0] out_data;
    logic                         ovf;
    logic                         ovf_clr;

    // Sample source / control side
    modport master (
        output code, code_wr, phase_clr, in_valid, i_in, q_in, ovf_clr,
        input  out_valid, out_data, ovf
    );

    // Upconverter side
    modport slave (
        input  code, code_wr, phase_clr, in_valid, i_in, q_in, ovf_clr,
        output out_valid, out_data, ovf
    );
endinterface

// File: rtl/iq_upconverter.sv
// Complex-to-real upconverter: out = I*cos(ph) - Q*sin(ph) with an internal NCO whose phase
// advances once per accepted sample. Fixed 4-cycle latency, no stalls, round half-up and
// saturate to the output width. The sin/cos table is built at elaboration from an integer
// Taylor series so the ROM contents need no external file.
module iq_upconverter #(
    parameter int unsigned WIDTH_DATA  = 14,
    parameter int unsigned IQ_WIDTH    = 9,
    parameter int unsigned PHASE_WIDTH = 10,
    parameter int unsigned ACC_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               reset,
    iq_upconverter_if.slave    bus
);

    localparam int unsigned DEPTH  = 1 << PHASE_WIDTH;
    localparam int unsigned QDEPTH = DEPTH / 4;
    localparam int unsigned LUT_W  = 2 * IQ_WIDTH;
    localparam int unsigned PROD_W = WIDTH_DATA + IQ_WIDTH;
    localparam int unsigned DIFF_W = PROD_W + 1;
    localparam int unsigned RND_W  = DIFF_W + 1;
    localparam int unsigned SHIFT  = IQ_WIDTH - 1;

    localparam int          ROUND_BIAS = 1 << (IQ_WIDTH - 2);
    localparam int          SAT_MAX    = (1 << (WIDTH_DATA - 1)) - 1;
    localparam int          SAT_MIN    = -(1 << (WIDTH_DATA - 1));

    // Fixed-point format for table generation: 28 fractional bits
    localparam longint      FX_ONE     = 64'sd1 << 28;
    localparam longint      FX_HALF_PI = 64'sd421657428;
    localparam longint      AMP        = longint'((1 << (IQ_WIDTH - 1)) - 1);

    // Fixed-point multiply, operands below 2^30 so the product fits in 64 bits
    function automatic longint fx_mul(input longint a, input longint b);
        return (a * b) / FX_ONE;
    endfunction

    // Angle of quarter-wave entry q in fixed point (0 .. just under pi/2)
    function automatic longint fx_angle(input int unsigned q);
        return (longint'(q) * FX_HALF_PI) / longint'(QDEPTH);
    endfunction

    // Rounded amplitude * sin(angle) over the first quadrant
    function automatic longint quarter_sin(input int unsigned q);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = fx_angle(q);
        x2   = fx_mul(x, x);
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -fx_mul(term, x2) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return (sum * AMP + FX_ONE / 2) / FX_ONE;
    endfunction

    // Rounded amplitude * cos(angle) over the first quadrant
    function automatic longint quarter_cos(input int unsigned q);
        longint x2;
        longint term;
        longint sum;
        x2   = fx_mul(fx_angle(q), fx_angle(q));
        term = FX_ONE;
        sum  = FX_ONE;
        for (int n = 1; n <= 9; n++) begin
            term = -fx_mul(term, x2) / longint'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return (sum * AMP + FX_ONE / 2) / FX_ONE;
    endfunction

    // Full-circle {cos,sin} word from quarter-wave symmetry
    function automatic logic [LUT_W-1:0] lut_word(input int unsigned k);
        int unsigned q;
        int unsigned quad;
        longint      c;
        longint      s;
        longint      cv;
        longint      sv;
        q    = k % QDEPTH;
        quad = (k / QDEPTH) % 4;
        c    = quarter_cos(q);
        s    = quarter_sin(q);
        case (quad)
            0:       begin cv = c;  sv = s;  end
            1:       begin cv = -s; sv = c;  end
            2:       begin cv = -c; sv = -s; end
            default: begin cv = s;  sv = -c; end
        endcase
        return {IQ_WIDTH'(cv), IQ_WIDTH'(sv)};
    endfunction

    logic [LUT_W-1:0] lut [DEPTH];

    // Constant ROM contents, one word per phase index
    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_lut
        localparam logic [LUT_W-1:0] WORD = lut_word(k);
        assign lut[k] = WORD;
    end

    logic [ACC_WIDTH-1:0]         code_reg;
    logic [ACC_WIDTH-1:0]         acc;
    logic [ACC_WIDTH-1:0]         acc_base_c;

    logic                         s1_valid;
    logic signed [WIDTH_DATA-1:0] s1_i;
    logic signed [WIDTH_DATA-1:0] s1_q;
    logic [PHASE_WIDTH-1:0]       s1_idx;

    logic                         s2_valid;
    logic signed [WIDTH_DATA-1:0] s2_i;
    logic signed [WIDTH_DATA-1:0] s2_q;
    logic signed [IQ_WIDTH-1:0]   cos_r;
    logic signed [IQ_WIDTH-1:0]   sin_r;

    logic                         s3_valid;
    logic signed [PROD_W-1:0]     prod_i;
    logic signed [PROD_W-1:0]     prod_q;

    logic                         s4_valid;
    logic signed [DIFF_W-1:0]     diff;

    logic signed [RND_W-1:0]      rnd_c;
    logic signed [RND_W-1:0]      shifted_c;
    logic signed [WIDTH_DATA-1:0] sat_data_c;
    logic                         sat_c;

    logic                         out_valid_q;
    logic signed [WIDTH_DATA-1:0] out_data_q;
    logic                         ovf_q;

    // phase_clr forces the tag and the accumulation base to zero
    assign acc_base_c = bus.phase_clr ? '0 : acc;

    // Frequency word register; a same-cycle sample still steps with the old word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_reg <= '0;
        end else if (bus.code_wr) begin
            code_reg <= bus.code;
        end
    end

    // Phase accumulator, advances only on accepted samples, wraps modulo 2^ACC_WIDTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (bus.in_valid) begin
            acc <= acc_base_c + code_reg;
        end else begin
            acc <= acc_base_c;
        end
    end

    // S1: capture sample and its phase index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_i     <= '0;
            s1_q     <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_i     <= bus.i_in;
            s1_q     <= bus.q_in;
            s1_idx   <= acc_base_c[ACC_WIDTH-1 -: PHASE_WIDTH];
        end
    end

    // S2: registered table lookup
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_i     <= '0;
            s2_q     <= '0;
            cos_r    <= '0;
            sin_r    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_i     <= s1_i;
            s2_q     <= s1_q;
            cos_r    <= $signed(lut[s1_idx][LUT_W-1 -: IQ_WIDTH]);
            sin_r    <= $signed(lut[s1_idx][IQ_WIDTH-1:0]);
        end
    end

    // S3: full-precision products
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            prod_i   <= '0;
            prod_q   <= '0;
        end else begin
            s3_valid <= s2_valid;
            prod_i   <= PROD_W'(s2_i) * PROD_W'(cos_r);
            prod_q   <= PROD_W'(s2_q) * PROD_W'(sin_r);
        end
    end

    // S4: difference with one guard bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s4_valid <= 1'b0;
            diff     <= '0;
        end else begin
            s4_valid <= s3_valid;
            diff     <= DIFF_W'(prod_i) - DIFF_W'(prod_q);
        end
    end

    // Round half-up, drop the table scaling, clamp to output range
    always_comb begin
        rnd_c      = RND_W'(diff) + RND_W'(ROUND_BIAS);
        shifted_c  = rnd_c >>> SHIFT;
        sat_c      = 1'b0;
        sat_data_c = WIDTH_DATA'(shifted_c);
        if (shifted_c > RND_W'(SAT_MAX)) begin
            sat_c      = 1'b1;
            sat_data_c = WIDTH_DATA'(SAT_MAX);
        end else if (shifted_c < RND_W'(SAT_MIN)) begin
            sat_c      = 1'b1;
            sat_data_c = WIDTH_DATA'(SAT_MIN);
        end
    end

    // Output register; data holds between valid samples, ovf is sticky with set priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= s4_valid;
            if (s4_valid) begin
                out_data_q <= sat_data_c;
            end
            if (s4_valid && sat_c) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_iq_upconverter.sv
// Bench for iq_upconverter: directed NCO/saturation/reset scenarios plus random traffic,
// all checked cycle by cycle against a real-arithmetic reference model.
`timescale 1ns/1ps
module tb_iq_upconverter;

    localparam int WD   = 14;
    localparam int IQW  = 9;
    localparam int PW   = 10;
    localparam int AW   = 32;
    localparam int NCYC = 8192;
    localparam int OMAX = (1 << (WD - 1)) - 1;
    localparam int OMIN = -(1 << (WD - 1));

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iq_upconverter_if #(.WIDTH_DATA(WD), .ACC_WIDTH(AW)) bus ();

    iq_upconverter #(
        .WIDTH_DATA (WD),
        .IQ_WIDTH   (IQW),
        .PHASE_WIDTH(PW),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [AW-1:0] m_acc;
    bit [AW-1:0] m_code;
    bit          m_ovf;
    int          m_hold;
    bit          exp_v [NCYC];
    int          exp_d [NCYC];
    bit          exp_s [NCYC];
    int          cap [$];
    bit          capturing;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Ideal NCO value: round(amplitude * cos/sin(2*pi*idx/2^PW)), half away from zero
    function automatic int nco(input int idx, input bit is_sin);
        real a;
        real v;
        a = 2.0 * 3.14159265358979323846 * real'(idx) / real'(1 << PW);
        v = real'((1 << (IQW - 1)) - 1) * (is_sin ? $sin(a) : $cos(a));
        if (v >= 0.0) return $rtoi($floor(v + 0.5));
        return -$rtoi($floor(0.5 - v));
    endfunction

    function automatic void ref_mix(input int i, input int q, input int idx,
                                    output int y, output bit sat);
        longint d;
        int     t;
        d   = longint'(i) * longint'(nco(idx, 1'b0)) - longint'(q) * longint'(nco(idx, 1'b1));
        t   = $rtoi($floor((real'(d) + real'(1 << (IQW - 2))) / real'(1 << (IQW - 1))));
        sat = 1'b0;
        y   = t;
        if (t > OMAX) begin y = OMAX; sat = 1'b1; end
        if (t < OMIN) begin y = OMIN; sat = 1'b1; end
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NCYC; k++) exp_v[k] = 1'b0;
        m_acc  = '0;
        m_code = '0;
        m_ovf  = 1'b0;
        m_hold = 0;
    endtask

    // One clock: drive at negedge, predict, check #1 after the rising edge
    task automatic tick(input bit iv, input int i, input int q, input bit cwr,
                        input bit [AW-1:0] cd, input bit pclr, input bit oclr);
        int n;
        int idx;
        int y;
        bit s;
        @(negedge clk);
        if (cyc > NCYC - 8) begin
            n_fail++;
            $display("FAIL cycle_budget: got %0d cycles expected at most %0d", cyc, NCYC - 8);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "cycle budget exhausted");
        end
        bus.in_valid  = iv;
        bus.i_in      = WD'(i);
        bus.q_in      = WD'(q);
        bus.code_wr   = cwr;
        bus.code      = cd;
        bus.phase_clr = pclr;
        bus.ovf_clr   = oclr;
        n = cyc + 1;
        if (!reset) begin
            if (iv) begin
                idx = pclr ? 0 : int'(m_acc >> (AW - PW));
                ref_mix(i, q, idx, y, s);
                exp_v[n + 4] = 1'b1;
                exp_d[n + 4] = y;
                exp_s[n + 4] = s;
                m_acc = (pclr ? '0 : m_acc) + m_code;
            end else if (pclr) begin
                m_acc = '0;
            end
            if (cwr) m_code = cd;
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            if (exp_v[cyc]) m_hold = exp_d[cyc];
            if (exp_v[cyc] && exp_s[cyc]) m_ovf = 1'b1;
            else if (oclr)                m_ovf = 1'b0;
        end
        check_val("out_valid", 64'(bus.out_valid), 64'(exp_v[cyc]));
        check_val("out_data", 64'(bus.out_data), 64'(m_hold));
        check_val("ovf", 64'(bus.ovf), 64'(m_ovf));
        if (capturing && bus.out_valid) cap.push_back(int'(bus.out_data));
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 0, 0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Reset asserted mid-cycle, outputs must clear immediately
    task automatic async_reset(input int hold);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check_val("rst_out_data", 64'(bus.out_data), 64'(0));
        check_val("rst_ovf", 64'(bus.ovf), 64'(0));
        model_clear();
        repeat (hold) tick(1'b1, 1000, -1000, 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        capturing     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.i_in      = '0;
        bus.q_in      = '0;
        bus.code_wr   = 1'b0;
        bus.code      = '0;
        bus.phase_clr = 1'b0;
        bus.ovf_clr   = 1'b0;
        model_clear();
        repeat (3) tick(1'b0, 0, 0, 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        idle(100);

        // Cosine carrier: 16-sample period
        tick(1'b0, 0, 0, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
        cap.delete();
        capturing = 1'b1;
        repeat (40) tick(1'b1, 4000, 0, 1'b0, '0, 1'b0, 1'b0);
        idle(6);
        check_val("cos_count", 64'(cap.size()), 64'(40));
        check_val("cos_s0", 64'(cap[0]), 64'(3984));
        check_val("cos_s4", 64'(cap[4]), 64'(0));
        check_val("cos_s8", 64'(cap[8]), 64'(-3984));
        check_val("cos_s16", 64'(cap[16]), 64'(3984));

        // Quadrature input, phase restarted on first sample
        cap.delete();
        tick(1'b1, 0, 4000, 1'b0, '0, 1'b1, 1'b0);
        repeat (19) tick(1'b1, 0, 4000, 1'b0, '0, 1'b0, 1'b0);
        idle(6);
        check_val("sin_s0", 64'(cap[0]), 64'(0));
        check_val("sin_s4", 64'(cap[4]), 64'(-3984));
        check_val("sin_s12", 64'(cap[12]), 64'(3984));

        // Saturation and sticky flag; clear collides with a saturating sample at k=6
        cap.delete();
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 8191, -8192, 1'b0, '0, k == 0, (k == 6) || (k == 8));
            if (k == 6) check_val("ovf_clr_vs_sat", 64'(bus.ovf), 64'(1));
            if (k == 8) check_val("ovf_clr", 64'(bus.ovf), 64'(0));
        end
        idle(6);
        check_val("sat_s0", 64'(cap[0]), 64'(8159));
        check_val("sat_s2", 64'(cap[2]), 64'(8191));
        check_val("ovf_sticky", 64'(bus.ovf), 64'(1));

        // New code and phase clear together with a sample, then toggling valid
        cap.delete();
        repeat (5) tick(1'b1, 4000, 0, 1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, 4000, 0, 1'b1, 32'h2000_0000, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) tick(k % 2 == 0, 4000, 0, 1'b0, '0, 1'b0, 1'b0);
        idle(6);
        check_val("clr_s0", 64'(cap[5]), 64'(3984));
        check_val("clr_s1", 64'(cap[6]), 64'(3688));
        check_val("clr_s2", 64'(cap[7]), 64'(1531));

        // Reset in the middle of a saturating stream
        tick(1'b1, 8191, -8192, 1'b1, 32'h1000_0000, 1'b1, 1'b0);
        repeat (9) tick(1'b1, 8191, -8192, 1'b0, '0, 1'b0, 1'b0);
        check_val("pre_rst_ovf", 64'(bus.ovf), 64'(1));
        async_reset(3);
        cap.delete();
        tick(1'b1, 4000, 0, 1'b1, 32'h1000_0000, 1'b0, 1'b0);
        repeat (20) tick(1'b1, 4000, 0, 1'b0, '0, 1'b0, 1'b0);
        idle(6);
        check_val("rst_count", 64'(cap.size()), 64'(21));
        check_val("rst_s0", 64'(cap[0]), 64'(3984));
        check_val("rst_s1", 64'(cap[1]), 64'(3984));
        check_val("rst_s2", 64'(cap[2]), 64'(3688));
        capturing = 1'b0;

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            tick($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 16383)) - 8192,
                 int'($urandom_range(0, 16383)) - 8192,
                 $urandom_range(0, 31) == 0,
                 $urandom,
                 $urandom_range(0, 63) == 0,
                 $urandom_range(0, 15) == 0);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
